// File: rtl/lcd_text_refresh.sv
// Frame sequencer feeding a 16x2 HD44780-style LCD driver.
// Streams two address commands and 32 buffered characters per redraw.
module lcd_text_refresh #(
    parameter logic [7:0]  LINE1_CMD    = 8'h80,
    parameter logic [7:0]  LINE2_CMD    = 8'hC0,
    parameter int unsigned ACK_TIMEOUT  = 16,
    parameter bit          AUTO_REFRESH = 1'b1
) (
    input  logic       clock,
    input  logic       internal_reset,
    input  logic       refresh,
    output logic [4:0] char_addr,
    input  logic [7:0] char_data,
    output logic [8:0] lcd_d_in,
    output logic       data_ready,
    input  logic       busy_flag,
    output logic       frame_busy,
    output logic       frame_done,
    output logic       ack_error
);

    typedef enum logic [2:0] {
        INIT_HI, INIT_LO, IDLE, FETCH, ISSUE, ACK, DONE
    } state_e;

    localparam int         TW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [5:0] LAST_IDX = 6'd33;

    state_e        state_q, state_d;
    logic [5:0]    idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          pending_q, pending_d;
    logic          fwait_q, fwait_d;
    logic [4:0]    char_addr_q, char_addr_d;
    logic [8:0]    lcd_d_q, lcd_d_d;
    logic          frame_busy_q, frame_busy_d;
    logic          frame_done_q, frame_done_d;
    logic          ack_error_q, ack_error_d;

    function automatic logic is_cmd(input logic [5:0] idx);
        return (idx == 6'd0) || (idx == 6'd17);
    endfunction

    // Line 2 characters sit two write slots past their buffer address.
    function automatic logic [4:0] addr_of(input logic [5:0] idx);
        return (idx < 6'd17) ? 5'(idx - 6'd1) : 5'(idx - 6'd2);
    endfunction

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tmo_d        = tmo_q;
        pending_d    = pending_q;
        fwait_d      = fwait_q;
        char_addr_d  = char_addr_q;
        lcd_d_d      = lcd_d_q;
        frame_busy_d = frame_busy_q;
        frame_done_d = 1'b0;
        ack_error_d  = ack_error_q;
        data_ready   = 1'b0;

        if (refresh) pending_d = 1'b1;

        unique case (state_q)
            INIT_HI: begin
                if (busy_flag) state_d = INIT_LO;
            end
            INIT_LO: begin
                if (!busy_flag) begin
                    state_d = IDLE;
                    if (AUTO_REFRESH) pending_d = 1'b1;
                end
            end
            IDLE: begin
                if (pending_q || refresh) begin
                    pending_d    = 1'b0;
                    frame_busy_d = 1'b1;
                    idx_d        = 6'd0;
                    fwait_d      = 1'b0;
                    state_d      = FETCH;
                end
            end
            FETCH: begin
                if (is_cmd(idx_q)) begin
                    lcd_d_d = {1'b0, (idx_q == 6'd0) ? LINE1_CMD : LINE2_CMD};
                    state_d = ISSUE;
                end else if (!fwait_q) begin
                    fwait_d = 1'b1;
                end else begin
                    lcd_d_d = {1'b1, char_data};
                    fwait_d = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!busy_flag) begin
                    data_ready = 1'b1;
                    tmo_d      = '0;
                    state_d    = ACK;
                end
            end
            ACK: begin
                if (busy_flag) begin
                    state_d = DONE;
                end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
                    ack_error_d  = 1'b1;
                    frame_busy_d = 1'b0;
                    state_d      = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            DONE: begin
                if (!busy_flag) begin
                    if (idx_q == LAST_IDX) begin
                        frame_done_d = 1'b1;
                        frame_busy_d = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        idx_d       = idx_q + 6'd1;
                        fwait_d     = 1'b0;
                        char_addr_d = addr_of(idx_q + 6'd1);
                        state_d     = FETCH;
                    end
                end
            end
            default: state_d = INIT_HI;
        endcase
    end

    always_ff @(posedge clock) begin
        if (internal_reset) begin
            state_q      <= INIT_HI;
            idx_q        <= '0;
            tmo_q        <= '0;
            pending_q    <= 1'b0;
            fwait_q      <= 1'b0;
            char_addr_q  <= '0;
            lcd_d_q      <= '0;
            frame_busy_q <= 1'b0;
            frame_done_q <= 1'b0;
            ack_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            tmo_q        <= tmo_d;
            pending_q    <= pending_d;
            fwait_q      <= fwait_d;
            char_addr_q  <= char_addr_d;
            lcd_d_q      <= lcd_d_d;
            frame_busy_q <= frame_busy_d;
            frame_done_q <= frame_done_d;
            ack_error_q  <= ack_error_d;
        end
    end

    assign char_addr  = char_addr_q;
    assign lcd_d_in   = lcd_d_q;
    assign frame_busy = frame_busy_q;
    assign frame_done = frame_done_q;
    assign ack_error  = ack_error_q;

endmodule

// File: tb/tb_lcd_text_refresh.sv
// Bench for lcd_text_refresh with a behavioural LCD driver and buffer.
// Expected write streams come from the frame layout applied to the buffer.
module tb_lcd_text_refresh;

    localparam int ACK_TIMEOUT = 16;

    logic       clock = 1'b0;
    logic       internal_reset = 1'b1;
    logic       refresh = 1'b0;
    logic [4:0] char_addr;
    logic [7:0] char_data;
    logic [8:0] lcd_d_in;
    logic       data_ready;
    logic       busy_flag = 1'b0;
    logic       frame_busy;
    logic       frame_done;
    logic       ack_error;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [32];
    logic [8:0] wlog [$];
    int fd_cnt = 0, overlap_err = 0, stab_err = 0, dr_long = 0, fd_long = 0;
    logic prev_dr = 1'b0, prev_fd = 1'b0;
    int init_left = 0, dly = 0, hold = 0, drv_writes = 0;
    int silent_at = 1 << 30;
    int frame_base = 0, fd_base = 0;

    lcd_text_refresh #(
        .LINE1_CMD(8'h80), .LINE2_CMD(8'hC0),
        .ACK_TIMEOUT(ACK_TIMEOUT), .AUTO_REFRESH(1'b1)
    ) dut (
        .clock(clock), .internal_reset(internal_reset), .refresh(refresh),
        .char_addr(char_addr), .char_data(char_data), .lcd_d_in(lcd_d_in),
        .data_ready(data_ready), .busy_flag(busy_flag),
        .frame_busy(frame_busy), .frame_done(frame_done), .ack_error(ack_error)
    );

    always #5 clock = ~clock;

    // Synchronous-read text buffer: data follows the address one cycle later.
    always @(posedge clock) char_data <= mem[char_addr];

    // Driver: busy during power-on init, then 2-cycle rise, 10 cycles high per write.
    always @(posedge clock) begin
        if (internal_reset) begin
            init_left <= 51; busy_flag <= 1'b0; dly <= 0; hold <= 0;
        end else if (init_left != 0) begin
            init_left <= init_left - 1;
            busy_flag <= (init_left != 1);
        end else if (dly != 0) begin
            dly <= dly - 1;
            if (dly == 1) begin busy_flag <= 1'b1; hold <= 10; end
        end else if (hold != 0) begin
            hold <= hold - 1;
            if (hold == 1) busy_flag <= 1'b0;
        end else if (data_ready && drv_writes < silent_at) begin
            dly <= 2;
            drv_writes <= drv_writes + 1;
        end
    end

    always @(posedge clock) begin
        if (data_ready) wlog.push_back(lcd_d_in);
        if (data_ready && busy_flag) overlap_err++;
        if (!internal_reset && (dly != 0 || hold != 0) && wlog.size() > 0
            && lcd_d_in !== wlog[wlog.size()-1]) stab_err++;
        if (frame_done) fd_cnt++;
        if (frame_done && prev_fd) fd_long++;
        if (data_ready && prev_dr) dr_long++;
        prev_dr <= data_ready;
        prev_fd <= frame_done;
    end

    function automatic logic [8:0] exp_write(input int k);
        if (k == 0) return 9'h080;
        if (k == 17) return 9'h0C0;
        if (k < 17) return {1'b1, mem[k-1]};
        return {1'b1, mem[k-2]};
    endfunction

    task automatic pulse_refresh();
        refresh = 1'b1;
        @(negedge clock);
        refresh = 1'b0;
    endtask

    task automatic test_reset();
        internal_reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (char_addr !== 5'd0) begin errors++; $display("FAIL reset_char_addr got %h want 0", char_addr); end
        checks++;
        if (lcd_d_in !== 9'd0) begin errors++; $display("FAIL reset_lcd_d_in got %h want 0", lcd_d_in); end
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_data_ready got %b want 0", data_ready); end
        checks++;
        if (frame_busy !== 1'b0) begin errors++; $display("FAIL reset_frame_busy got %b want 0", frame_busy); end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        checks++;
        if (ack_error !== 1'b0) begin errors++; $display("FAIL reset_ack_error got %b want 0", ack_error); end
        frame_base = wlog.size();
        fd_base = fd_cnt;
        internal_reset = 1'b0;
    endtask

    task automatic test_powerup();
        int cyc;
        bit seen;
        cyc = 0; seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clock);
            cyc++;
            if (data_ready) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL powerup_strobe got none want strobe within 300"); end
        checks++;
        if (cyc < 50) begin errors++; $display("FAIL powerup_wait got %0d cycles want >=50", cyc); end
        checks++;
        if (lcd_d_in !== 9'h080) begin errors++; $display("FAIL powerup_first_write got %h want 080", lcd_d_in); end
        checks++;
        if (frame_busy !== 1'b1) begin errors++; $display("FAIL powerup_frame_busy got %b want 1", frame_busy); end
        @(negedge clock);
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL powerup_single_strobe got %b want 0", data_ready); end
    endtask

    task automatic test_full_frame();
        bit ok;
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clock);
            if (fd_cnt > fd_base) ok = 1;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL frame_done_wait got none want pulse within 2000"); end
        checks++;
        if (wlog.size() - frame_base != 34) begin
            errors++; $display("FAIL frame_write_count got %0d want 34", wlog.size() - frame_base);
        end else begin
            for (int k = 0; k < 34; k++) begin
                checks++;
                if (wlog[frame_base+k] !== exp_write(k)) begin
                    errors++; $display("FAIL frame_write_%0d got %h want %h", k, wlog[frame_base+k], exp_write(k));
                end
            end
        end
        @(negedge clock);
        checks++;
        if (frame_busy !== 1'b0) begin errors++; $display("FAIL frame_busy_after got %b want 0", frame_busy); end
        checks++;
        if (fd_cnt != fd_base + 1 || fd_long != 0) begin
            errors++; $display("FAIL frame_done_pulse got %0d pulses, %0d long want 1, 0", fd_cnt - fd_base, fd_long);
        end
        checks++;
        if (stab_err != 0 || overlap_err != 0 || dr_long != 0) begin
            errors++; $display("FAIL frame_protocol got stab=%0d overlap=%0d long=%0d want 0", stab_err, overlap_err, dr_long);
        end
    endtask

    task automatic test_coalesce();
        int base, fd0;
        bit ok;
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        base = wlog.size(); fd0 = fd_cnt; ok = 0;
        pulse_refresh();
        repeat (60 + $urandom_range(0, 40)) @(negedge clock);
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (frame_busy !== 1'b1) begin errors++; $display("FAIL coalesce_mid_frame_%0d got %b want 1", p, frame_busy); end
            pulse_refresh();
            repeat ($urandom_range(5, 50)) @(negedge clock);
        end
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clock);
            if (fd_cnt >= fd0 + 2) ok = 1;
        end
        repeat (300) @(negedge clock);
        checks++;
        if (fd_cnt != fd0 + 2) begin errors++; $display("FAIL coalesce_frames got %0d want 2", fd_cnt - fd0); end
        checks++;
        if (wlog.size() - base != 68) begin
            errors++; $display("FAIL coalesce_writes got %0d want 68", wlog.size() - base);
        end else begin
            for (int k = 0; k < 68; k++) begin
                checks++;
                if (wlog[base+k] !== exp_write(k % 34)) begin
                    errors++; $display("FAIL coalesce_write_%0d got %h want %h", k, wlog[base+k], exp_write(k % 34));
                end
            end
        end
        checks++;
        if (overlap_err != 0 || stab_err != 0) begin
            errors++; $display("FAIL coalesce_protocol got overlap=%0d stab=%0d want 0", overlap_err, stab_err);
        end
    endtask

    task automatic test_timeout();
        int base, fd0, n, cyc;
        bit ok;
        checks++;
        if (ack_error !== 1'b0) begin errors++; $display("FAIL timeout_pre_error got %b want 0", ack_error); end
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        base = wlog.size(); fd0 = fd_cnt; n = 0; cyc = 0; ok = 0;
        silent_at = drv_writes + 5;
        pulse_refresh();
        for (int i = 0; i < 1000 && n < 6; i++) begin
            if (data_ready) n++;
            if (n < 6) @(negedge clock);
        end
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clock);
            cyc++;
            if (ack_error) ok = 1;
        end
        checks++;
        if (!ok || cyc < ACK_TIMEOUT || cyc > ACK_TIMEOUT + 2) begin
            errors++; $display("FAIL timeout_latency got %0d cycles want %0d..%0d", cyc, ACK_TIMEOUT, ACK_TIMEOUT + 2);
        end
        checks++;
        if (frame_busy !== 1'b0) begin errors++; $display("FAIL timeout_frame_busy got %b want 0", frame_busy); end
        repeat (50) @(negedge clock);
        checks++;
        if (fd_cnt != fd0) begin errors++; $display("FAIL timeout_no_done got %0d want 0", fd_cnt - fd0); end
        checks++;
        if (wlog.size() - base != 6) begin
            errors++; $display("FAIL timeout_writes got %0d want 6", wlog.size() - base);
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (wlog[base+k] !== exp_write(k)) begin
                    errors++; $display("FAIL timeout_write_%0d got %h want %h", k, wlog[base+k], exp_write(k));
                end
            end
        end
        silent_at = 1 << 30;
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        base = wlog.size(); fd0 = fd_cnt; ok = 0;
        pulse_refresh();
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clock);
            if (fd_cnt > fd0) ok = 1;
        end
        checks++;
        if (!ok || wlog.size() - base != 34) begin
            errors++; $display("FAIL timeout_refresh_frame got %0d writes want 34", wlog.size() - base);
        end else begin
            for (int k = 0; k < 34; k++) begin
                checks++;
                if (wlog[base+k] !== exp_write(k)) begin
                    errors++; $display("FAIL timeout_refresh_write_%0d got %h want %h", k, wlog[base+k], exp_write(k));
                end
            end
        end
        checks++;
        if (ack_error !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b want 1", ack_error); end
    endtask

    task automatic test_reset_mid();
        int base, fd0, n, cyc;
        bit ok;
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        fd0 = fd_cnt; n = 0; cyc = 0; ok = 0;
        pulse_refresh();
        for (int i = 0; i < 1000 && n < 20; i++) begin
            if (data_ready) n++;
            if (n < 20) @(negedge clock);
        end
        internal_reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({char_addr, lcd_d_in, data_ready, frame_busy, frame_done, ack_error} !== 19'd0) begin
            errors++;
            $display("FAIL midreset_outputs got addr=%h d=%h dr=%b fb=%b fd=%b err=%b want all 0",
                     char_addr, lcd_d_in, data_ready, frame_busy, frame_done, ack_error);
        end
        @(negedge clock);
        base = wlog.size();
        internal_reset = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clock);
            cyc++;
            if (data_ready) ok = 1;
        end
        checks++;
        if (!ok || cyc < 50) begin errors++; $display("FAIL midreset_rewait got %0d cycles want >=50", cyc); end
        checks++;
        if (lcd_d_in !== 9'h080) begin errors++; $display("FAIL midreset_first_write got %h want 080", lcd_d_in); end
        checks++;
        if (fd_cnt != fd0) begin errors++; $display("FAIL midreset_no_done got %0d want 0", fd_cnt - fd0); end
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clock);
            if (fd_cnt > fd0) ok = 1;
        end
        checks++;
        if (!ok || wlog.size() - base != 34) begin
            errors++; $display("FAIL midreset_frame got %0d writes want 34", wlog.size() - base);
        end else begin
            for (int k = 0; k < 34; k++) begin
                checks++;
                if (wlog[base+k] !== exp_write(k)) begin
                    errors++; $display("FAIL midreset_write_%0d got %h want %h", k, wlog[base+k], exp_write(k));
                end
            end
        end
        checks++;
        if (overlap_err != 0 || stab_err != 0 || dr_long != 0 || fd_long != 0) begin
            errors++;
            $display("FAIL final_protocol got overlap=%0d stab=%0d drlong=%0d fdlong=%0d want 0",
                     overlap_err, stab_err, dr_long, fd_long);
        end
    endtask

    initial begin
        string s1, s2;
        s1 = "0123456789ABCDEF";
        s2 = "ghijklmnopqrstuv";
        for (int i = 0; i < 16; i++) begin
            mem[i] = s1[i];
            mem[16+i] = s2[i];
        end
        test_reset();
        test_powerup();
        test_full_frame();
        test_coalesce();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_text_refresh.md
Name: lcd_text_refresh

Overview:
Upstream sequencer for the 16x2 HD44780-style LCD driver. It reads 32 characters from a text buffer and issues 34 writes to the driver's 9-bit command/data port: set the line-1 address, send 16 characters, set the line-2 address, send 16 characters. Each write uses the driver's single-cycle data_ready strobe and its busy_flag. The calculator core requests a redraw with a one-cycle refresh pulse.

Parameters:
LINE1_CMD, 8'h80, DDRAM set-address command for line 1, column 0
LINE2_CMD, 8'hC0, DDRAM set-address command for line 2, column 0
ACK_TIMEOUT, 16, cycles after a data_ready pulse within which busy_flag must rise
AUTO_REFRESH, 1, if 1, one frame starts automatically when driver init completes

Ports:
clock  in  1  system clock; single clock domain
internal_reset  in  1  synchronous, active-high reset
refresh  in  1  one-cycle redraw request
char_addr  out  5  text buffer read address (0-15 line 1, 16-31 line 2)
char_data  in  8  buffer read data, valid exactly 1 cycle after char_addr changes
lcd_d_in  out  9  to driver d_in; bit 8 = RS (0 command, 1 character), bits 7:0 = byte
data_ready  out  1  one-cycle write strobe to the driver
busy_flag  in  1  driver busy indicator
frame_busy  out  1  high while a frame is in progress
frame_done  out  1  one-cycle pulse after the 34th write completes
ack_error  out  1  sticky; set on an acknowledge timeout

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: char_addr=0, lcd_d_in=0, data_ready=0, frame_busy=0, frame_done=0, ack_error=0, pending=0, state=INIT_HI.
- Reset mid-frame aborts the frame with no completion pulse, returns to INIT_HI and re-waits for driver init.
- INIT_HI: wait for busy_flag=1, since the driver raises it during power-on init. Go to INIT_LO.
- INIT_LO: wait for busy_flag=0. Go to IDLE. Set pending=AUTO_REFRESH.
- IDLE: if pending or refresh, clear pending, set frame_busy=1, set idx=0, go to FETCH.
- Write index idx runs 0..33:
  - idx 0 is command LINE1_CMD.
  - idx 1-16 are characters from addresses 0-15.
  - idx 17 is command LINE2_CMD.
  - idx 18-33 are characters from addresses 16-31.
- FETCH:
  - Drive char_addr for a character index, then wait one cycle for char_data.
  - Command indices pass through FETCH in 1 cycle without a buffer read.
- ISSUE:
  - Load lcd_d_in with {0,cmd} or {1,char_data}.
  - Pulse data_ready=1 for exactly one cycle and clear the timeout counter.
  - Go to ACK.
- ACK:
  - Wait for busy_flag=1. The driver raises it 2 cycles after the strobe.
  - On rise, go to DONE.
  - If ACK_TIMEOUT cycles elapse with no rise: set ack_error, drop frame_busy, return to IDLE (frame abandoned, no frame_done).
- DONE:
  - Wait for busy_flag=0.
  - If idx=33: pulse frame_done, drop frame_busy, go to IDLE.
  - Otherwise increment idx and go to FETCH.
- lcd_d_in is held stable from ISSUE through the DONE exit. The driver samples it after the strobe.
- data_ready is never asserted outside ISSUE, and never while busy_flag=1.
- refresh during a frame sets pending=1. Multiple requests coalesce into one. The next frame starts in IDLE on the cycle after frame_done.
- refresh while still in INIT_HI or INIT_LO sets pending.
- refresh coincident with frame_done: pending is captured, frame restarts.
- ack_error clears only on reset.

Test Plan:
1. Power-up handshake: model the driver with busy high for 50 cycles after reset, then low; AUTO_REFRESH=1 -> frame starts, first write lcd_d_in=9'h080 with a single data_ready pulse.
2. Full frame: buffer holds "0123456789ABCDEF" / "ghijklmnopqrstuv"; model busy 2-cycle rise, 10 cycles high -> 34 writes in order 080, 130..146, 0C0, 167..176, then one frame_done pulse; lcd_d_in stable during each busy window.
3. Coalesced refresh: pulse refresh 3 times mid-frame -> exactly one additional frame starts after frame_done; no strobe overlaps busy.
4. Ack timeout: model never raises busy after write 5 -> ack_error=1 at 16 cycles; frame_busy=0; no frame_done; the next refresh starts a fresh frame from idx 0 with ack_error still 1.
5. Reset mid-frame at write 20 -> all outputs return to reset values the next cycle; the block re-waits for the busy high-then-low sequence before writing 080.
6. Buffer latency: change char_data only 1 cycle after char_addr -> correct characters are captured; random buffer contents match the written bytes.
